// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition sequencer: source-select codes and FSM state encoding.
package acq_pkg;

  localparam int unsigned SEL_W = 2;

  localparam logic [SEL_W-1:0] SRC_SIM  = 2'd0;
  localparam logic [SEL_W-1:0] SRC_HS_A = 2'd1;
  localparam logic [SEL_W-1:0] SRC_HS_B = 2'd2;
  localparam logic [SEL_W-1:0] SRC_2308 = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM_WAIT = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } acq_state_t;

endpackage

// File: rtl/acq_src_mux.sv
// Registered 4:1 acquisition stream mux with HS offset-binary to signed conversion.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   sel                 latched source select (acq_pkg SRC_* codes)
//   sim_*, hs_*, adc2308_*  input streams
//   emit                register the selected sample this cycle (from the sequencer)
//   sel_valid_c         combinational valid of the selected stream
//   data_out/_valid     registered output sample stream
module acq_src_mux
  import acq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HS_W   = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] sim_data,
  input  logic              sim_valid,
  input  logic [HS_W-1:0]   hs_data_a,
  input  logic [HS_W-1:0]   hs_data_b,
  input  logic              hs_valid,
  input  logic [DATA_W-1:0] adc2308_data,
  input  logic              adc2308_valid,
  input  logic              emit,
  output logic              sel_valid_c,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid
);

  logic [DATA_W-1:0] sel_data;

  // Offset binary to two's complement: flip the MSB, then sign-extend from it.
  function automatic logic [DATA_W-1:0] hs_to_signed(input logic [HS_W-1:0] d);
    return {{(DATA_W-HS_W){~d[HS_W-1]}}, ~d[HS_W-1], d[HS_W-2:0]};
  endfunction

  // Select stream
  always_comb begin
    sel_valid_c = 1'b0;
    sel_data    = '0;
    case (sel)
      SRC_SIM: begin
        sel_valid_c = sim_valid;
        sel_data    = sim_data;
      end
      SRC_HS_A: begin
        sel_valid_c = hs_valid;
        sel_data    = hs_to_signed(hs_data_a);
      end
      SRC_HS_B: begin
        sel_valid_c = hs_valid;
        sel_data    = hs_to_signed(hs_data_b);
      end
      default: begin
        sel_valid_c = adc2308_valid;
        sel_data    = adc2308_data;
      end
    endcase
  end

  // Output register; data holds between emitted samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= emit;
      if (emit) begin
        data_out <= sel_data;
      end
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Capture sequencer: source select, front-end enable, optional trigger, decimated
// fixed-length or continuous sample stream with start/busy/done handshake.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start, abort          host control (start accepted only in IDLE, abort wins)
//   source_sel, n_samples, decim, trig_mode  capture config, latched on start
//   trig_in               external trigger level (rising edge arms capture)
//   sim_*, hs_*, adc2308_*  input streams
//   source_enable, busy   high while armed or capturing
//   data_out/_valid       output stream, 1 cycle after input valid
//   done                  pulse after a finite capture completes
//   sample_count          samples emitted in current/last capture
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned HS_W   = 14,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        source_sel,
  input  logic [CNT_W-1:0]  n_samples,
  input  logic [CNT_W-1:0]  decim,
  input  logic              trig_mode,
  input  logic              trig_in,
  input  logic [DATA_W-1:0] sim_data,
  input  logic              sim_valid,
  input  logic [HS_W-1:0]   hs_data_a,
  input  logic [HS_W-1:0]   hs_data_b,
  input  logic              hs_valid,
  input  logic [DATA_W-1:0] adc2308_data,
  input  logic              adc2308_valid,
  output logic              source_enable,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sample_count
);

  acq_state_t        state, state_d;
  logic [SEL_W-1:0]  cfg_src, cfg_src_d;
  logic [CNT_W-1:0]  cfg_n, cfg_n_d;
  logic [CNT_W-1:0]  cfg_decim, cfg_decim_d;
  logic [CNT_W-1:0]  dec_cnt, dec_cnt_d;
  logic [CNT_W-1:0]  count_d;
  logic              trig_prev;
  logic              busy_d;
  logic              done_d;
  logic              sel_valid_c;
  logic              emit_c;

  acq_src_mux #(
    .DATA_W (DATA_W),
    .HS_W   (HS_W)
  ) u_mux (
    .clk            (clk),
    .reset_n        (reset_n),
    .sel            (cfg_src),
    .sim_data       (sim_data),
    .sim_valid      (sim_valid),
    .hs_data_a      (hs_data_a),
    .hs_data_b      (hs_data_b),
    .hs_valid       (hs_valid),
    .adc2308_data   (adc2308_data),
    .adc2308_valid  (adc2308_valid),
    .emit           (emit_c),
    .sel_valid_c    (sel_valid_c),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cfg_src       <= SRC_SIM;
      cfg_n         <= '0;
      cfg_decim     <= '0;
      dec_cnt       <= '0;
      sample_count  <= '0;
      trig_prev     <= 1'b0;
      busy          <= 1'b0;
      source_enable <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      cfg_src       <= cfg_src_d;
      cfg_n         <= cfg_n_d;
      cfg_decim     <= cfg_decim_d;
      dec_cnt       <= dec_cnt_d;
      sample_count  <= count_d;
      trig_prev     <= trig_in;
      busy          <= busy_d;
      source_enable <= busy_d;
      done          <= done_d;
    end
  end

  // Next state, counters and config latch.
  // Emitting when the decimation counter is 0 makes the first valid of a capture
  // always go out and then every (decim+1)-th valid after it.
  always_comb begin
    state_d     = state;
    cfg_src_d   = cfg_src;
    cfg_n_d     = cfg_n;
    cfg_decim_d = cfg_decim;
    dec_cnt_d   = dec_cnt;
    count_d     = sample_count;
    done_d      = 1'b0;
    emit_c      = (state == CAPTURE) && sel_valid_c && (dec_cnt == '0);

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d     = trig_mode ? ARM_WAIT : CAPTURE;
          cfg_src_d   = source_sel;
          cfg_n_d     = n_samples;
          cfg_decim_d = decim;
          dec_cnt_d   = '0;
          count_d     = '0;
        end
      end
      ARM_WAIT: begin
        if (trig_in && !trig_prev) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (sel_valid_c) begin
          dec_cnt_d = (dec_cnt == cfg_decim) ? '0 : dec_cnt + CNT_W'(1);
        end
        if (emit_c) begin
          count_d = sample_count + CNT_W'(1);
          if ((cfg_n != '0) && (count_d == cfg_n)) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    endcase

    if (abort) begin
      state_d = IDLE;
    end

    busy_d = (state_d == ARM_WAIT) || (state_d == CAPTURE);
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer against a sample-list reference model.
module tb_acq_sequencer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HS_W   = 14;
  localparam int unsigned CNT_W  = 32;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_CAP  = 2;
  localparam int M_DONE = 3;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, abort;
  logic [1:0]        source_sel;
  logic [CNT_W-1:0]  n_samples, decim;
  logic              trig_mode, trig_in;
  logic [DATA_W-1:0] sim_data;
  logic              sim_valid;
  logic [HS_W-1:0]   hs_data_a, hs_data_b;
  logic              hs_valid;
  logic [DATA_W-1:0] adc2308_data;
  logic              adc2308_valid;
  logic              source_enable;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              busy, done;
  logic [CNT_W-1:0]  sample_count;

  int errors = 0;
  int checks = 0;

  // reference model state
  int                m_mode;
  logic [1:0]        m_src;
  logic [CNT_W-1:0]  m_n, m_decim, m_count;
  longint unsigned   m_vidx;
  logic              prev_trig, fin_pend;
  logic              exp_dv, exp_done;
  logic [DATA_W-1:0] exp_do;

  always #5 clk = ~clk;

  acq_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .source_sel     (source_sel),
    .n_samples      (n_samples),
    .decim          (decim),
    .trig_mode      (trig_mode),
    .trig_in        (trig_in),
    .sim_data       (sim_data),
    .sim_valid      (sim_valid),
    .hs_data_a      (hs_data_a),
    .hs_data_b      (hs_data_b),
    .hs_valid       (hs_valid),
    .adc2308_data   (adc2308_data),
    .adc2308_valid  (adc2308_valid),
    .source_enable  (source_enable),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .busy           (busy),
    .done           (done),
    .sample_count   (sample_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Offset binary code to signed value: code - 2^(HS_W-1)
  function automatic logic [DATA_W-1:0] hs_value(input logic [HS_W-1:0] d);
    int v;
    v = int'({18'd0, d}) - 8192;
    return DATA_W'(v);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_src = 2'd0; m_n = '0; m_decim = '0; m_count = '0; m_vidx = 0;
    prev_trig = 1'b0; fin_pend = 1'b0; exp_dv = 1'b0; exp_done = 1'b0; exp_do = '0;
  endtask

  task automatic quiet_inputs();
    start = 1'b0; abort = 1'b0; source_sel = 2'd0; n_samples = '0; decim = '0;
    trig_mode = 1'b0; trig_in = 1'b0; sim_data = '0; sim_valid = 1'b0;
    hs_data_a = '0; hs_data_b = '0; hs_valid = 1'b0; adc2308_data = '0; adc2308_valid = 1'b0;
  endtask

  task automatic rand_streams(input int unsigned pct);
    sim_data      = $urandom;
    hs_data_a     = HS_W'($urandom);
    hs_data_b     = HS_W'($urandom);
    adc2308_data  = $urandom;
    sim_valid     = ($urandom_range(99) < pct);
    hs_valid      = ($urandom_range(99) < pct);
    adc2308_valid = ($urandom_range(99) < pct);
  endtask

  // Advance the model over the current inputs, clock once, compare outputs.
  task automatic tick();
    logic              sv;
    logic [DATA_W-1:0] sd;
    exp_done = fin_pend;
    fin_pend = 1'b0;
    exp_dv   = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (start && !abort) begin
          m_src = source_sel; m_n = n_samples; m_decim = decim;
          m_count = '0; m_vidx = 0;
          m_mode = trig_mode ? M_ARM : M_CAP;
        end
      end
      M_ARM: begin
        if (abort) m_mode = M_IDLE;
        else if (trig_in && !prev_trig) m_mode = M_CAP;
      end
      M_CAP: begin
        case (m_src)
          2'd0:    begin sv = sim_valid;     sd = sim_data;            end
          2'd1:    begin sv = hs_valid;      sd = hs_value(hs_data_a); end
          2'd2:    begin sv = hs_valid;      sd = hs_value(hs_data_b); end
          default: begin sv = adc2308_valid; sd = adc2308_data;        end
        endcase
        if (sv) begin
          if ((m_vidx % (longint'(m_decim) + 1)) == 0) begin
            exp_dv = 1'b1; exp_do = sd; m_count = m_count + 1;
          end
          m_vidx++;
        end
        if (abort) m_mode = M_IDLE;
        else if (exp_dv && (m_n != 0) && (m_count == m_n)) begin
          m_mode = M_DONE; fin_pend = 1'b1;
        end
      end
      default: m_mode = M_IDLE;
    endcase
    prev_trig = trig_in;
    @(posedge clk);
    #1;
    chk("data_out_valid", 32'(data_out_valid), 32'(exp_dv));
    chk("data_out", data_out, exp_do);
    chk("busy", 32'(busy), 32'((m_mode == M_ARM) || (m_mode == M_CAP)));
    chk("source_enable", 32'(source_enable), 32'((m_mode == M_ARM) || (m_mode == M_CAP)));
    chk("done", 32'(done), 32'(exp_done));
    chk("sample_count", sample_count, m_count);
  endtask

  task automatic begin_capture(input logic [1:0] src, input logic [CNT_W-1:0] n,
                               input logic [CNT_W-1:0] d, input logic tm);
    source_sel = src; n_samples = n; decim = d; trig_mode = tm; start = 1'b1;
    tick();
    start = 1'b0;
    n_samples = CNT_W'($urandom_range(50));
    decim = CNT_W'($urandom_range(5));
    source_sel = 2'($urandom);
  endtask

  initial begin
    quiet_inputs();
    model_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src_en", 32'(source_enable), 32'd0);
    chk("rst_dv", 32'(data_out_valid), 32'd0);
    chk("rst_data", data_out, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", sample_count, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // simulation source, 4 back-to-back samples
    begin_capture(2'd0, 32'd4, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rand_streams(50);
      sim_valid = 1'b1; sim_data = 32'(10 + i);
      tick();
    end
    rand_streams(0);
    tick(); tick(); tick();
    chk("sim_final_count", sample_count, 32'd4);
    chk("sim_last_data", data_out, 32'd13);

    // HS channel B, decimate by 3
    begin_capture(2'd2, 32'd3, 32'd2, 1'b0);
    for (int i = 0; i < 9; i++) begin
      rand_streams(50);
      hs_valid = 1'b1; hs_data_b = HS_W'(14'h2000 + i);
      tick();
    end
    rand_streams(0);
    tick(); tick();
    chk("hsb_last_data", data_out, 32'd6);
    chk("hsb_count", sample_count, 32'd3);

    // HS channel A, negative full scale
    begin_capture(2'd1, 32'd1, 32'd0, 1'b0);
    rand_streams(0); hs_valid = 1'b1; hs_data_a = '0;
    tick();
    chk("hsa_neg_fs", data_out, 32'hFFFF_E000);
    rand_streams(0);
    tick(); tick();

    // trigger held high before start, then a real edge
    trig_in = 1'b1;
    tick();
    begin_capture(2'd0, 32'd3, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_streams(60);
      tick();
    end
    chk("arm_no_capture", sample_count, 32'd0);
    rand_streams(60); trig_in = 1'b0; tick();
    rand_streams(60); trig_in = 1'b1; tick();
    for (int i = 0; i < 20; i++) begin
      rand_streams(60);
      tick();
    end
    chk("trig_count", sample_count, 32'd3);
    trig_in = 1'b0;

    // ADC 2308 continuous, 100 samples, then abort
    begin_capture(2'd3, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 2000 && m_count != 100; i++) begin
      rand_streams(70);
      tick();
    end
    chk("cont_reached_100", m_count, 32'd100);
    rand_streams(0); abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cont_abort_busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("cont_no_done", 32'(done), 32'd0);
    chk("cont_count_held", sample_count, 32'd100);

    // start together with abort stays idle
    source_sel = 2'd0; n_samples = 32'd2; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
    tick();

    // start while busy is ignored; latched length kept
    begin_capture(2'd0, 32'd5, 32'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      rand_streams(40);
      if (i == 3) begin n_samples = 32'd2; start = 1'b1; end
      else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("busy_start_count", sample_count, 32'd5);

    // final sample coinciding with abort is still emitted, no done
    begin_capture(2'd0, 32'd2, 32'd0, 1'b0);
    rand_streams(0); sim_valid = 1'b1; tick();
    rand_streams(0); sim_valid = 1'b1; abort = 1'b1; tick();
    abort = 1'b0; rand_streams(0);
    tick(); tick();
    chk("abort_last_count", sample_count, 32'd2);

    // randomized captures
    for (int r = 0; r < 16; r++) begin
      begin_capture(2'($urandom), ($urandom_range(3) == 0) ? 32'd0 : CNT_W'($urandom_range(1, 8)),
                    CNT_W'($urandom_range(3)), 1'($urandom));
      for (int i = 0; i < 40; i++) begin
        rand_streams(60);
        trig_in = ($urandom_range(9) < 3);
        abort = ($urandom_range(99) < 3);
        start = ($urandom_range(99) < 5);
        tick();
      end
      abort = 1'b1; start = 1'b0; tick();
      abort = 1'b0; trig_in = 1'b0; rand_streams(0);
      tick();
    end

    // asynchronous reset in the middle of a capture
    begin_capture(2'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rand_streams(0); sim_valid = 1'b1; tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_src_en", 32'(source_enable), 32'd0);
    chk("arst_dv", 32'(data_out_valid), 32'd0);
    chk("arst_data", data_out, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", sample_count, 32'd0);
    quiet_inputs();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
